// File: rtl/mmx_pkg.sv
// mmx_pkg: shared MMX register-file constants and the writeback entry type
package mmx_pkg;

    localparam int MMX_NUM_REGS = 8;
    localparam int MMX_SEL_W    = $clog2(MMX_NUM_REGS);
    localparam int MMX_DATA_W   = 64;

    typedef struct packed {
        logic [MMX_SEL_W-1:0]  sel;
        logic [MMX_DATA_W-1:0] data;
    } mmx_wb_entry_t;

endpackage

// File: rtl/mmx_writeback_if.sv
// mmx_writeback_if: execute-side handshake, register-file write, scoreboard clear and bypass signals
interface mmx_writeback_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int SEL_W  = 3,
    localparam int CNT_W = $clog2(DEPTH) + 1
);
    logic              in_valid;
    logic              in_ready;
    logic [SEL_W-1:0]  in_reg;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              stall_wb;
    logic              rf_we;
    logic [SEL_W-1:0]  rf_sel;
    logic [DATA_W-1:0] rf_data;
    logic              write_enable;
    logic [SEL_W-1:0]  write_select;
    logic [SEL_W-1:0]  byp_sel;
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;

    modport slave (
        input  in_valid, in_reg, in_data, flush, stall_wb, byp_sel,
        output in_ready, rf_we, rf_sel, rf_data, write_enable, write_select,
               byp_hit, byp_data, count, empty, full
    );

    modport master (
        output in_valid, in_reg, in_data, flush, stall_wb, byp_sel,
        input  in_ready, rf_we, rf_sel, rf_data, write_enable, write_select,
               byp_hit, byp_data, count, empty, full
    );
endinterface

// File: rtl/mmx_wb_queue.sv
// mmx_wb_queue: in-order circular entry store with head/tail pointers, occupancy and flush
module mmx_wb_queue
    import mmx_pkg::*;
#(
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  mmx_wb_entry_t i_entry,
    output mmx_wb_entry_t o_entries [DEPTH],
    output logic [DEPTH-1:0] o_valid,
    output logic [PTR_W-1:0] o_head_ptr,
    output mmx_wb_entry_t o_head,
    output logic [CNT_W-1:0] o_count,
    output logic          o_empty,
    output logic          o_full
);
    mmx_wb_entry_t    r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    // pointers and occupancy; flush collapses the head onto the tail
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= r_tail;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + 1'b1;
            if (i_pop)  r_head <= r_head + 1'b1;
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    // entry payloads need no reset; validity is derived from the pointers
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_tail] <= i_entry;
    end

    // an entry is live when its distance from the head is below the occupancy
    always_comb begin
        o_valid = '0;
        for (int i = 0; i < DEPTH; i++)
            o_valid[i] = {1'b0, PTR_W'(i) - r_head} < r_count;
    end

    assign o_entries  = r_mem;
    assign o_head_ptr = r_head;
    assign o_count    = r_count;
    assign o_empty    = r_count == '0;
    assign o_full     = r_count == CNT_W'(DEPTH);
    assign o_head     = o_empty ? '0 : r_mem[r_head];
endmodule

// File: rtl/mmx_writeback.sv
// mmx_writeback: buffers MMX results and commits one per cycle to the register file and scoreboard
module mmx_writeback
    import mmx_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = MMX_DATA_W,
    parameter int SEL_W  = MMX_SEL_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic clk,
    input  logic reset,
    mmx_writeback_if.slave bus
);
    mmx_wb_entry_t     w_entry;
    mmx_wb_entry_t     w_entries [DEPTH];
    mmx_wb_entry_t     w_head;
    logic [DEPTH-1:0]  w_valid;
    logic [PTR_W-1:0]  w_head_ptr;
    logic [PTR_W-1:0]  w_idx;
    logic [CNT_W-1:0]  w_count;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [SEL_W-1:0]  w_head_sel;
    logic [DATA_W-1:0] w_head_data;
    logic              w_byp_hit;
    logic [DATA_W-1:0] w_byp_data;

    assign w_pop   = !w_empty & !bus.stall_wb & !bus.flush;
    assign w_push  = bus.in_valid & bus.in_ready;
    assign w_entry = {bus.in_reg, bus.in_data};

    mmx_wb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_flush    (bus.flush),
        .i_entry    (w_entry),
        .o_entries  (w_entries),
        .o_valid    (w_valid),
        .o_head_ptr (w_head_ptr),
        .o_head     (w_head),
        .o_count    (w_count),
        .o_empty    (w_empty),
        .o_full     (w_full)
    );

    // walk oldest to youngest so the last match seen is the youngest
    always_comb begin
        w_byp_hit  = 1'b0;
        w_byp_data = '0;
        w_idx      = w_head_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = w_head_ptr + PTR_W'(k);
            if (w_valid[w_idx] && w_entries[w_idx].sel == bus.byp_sel) begin
                w_byp_hit  = 1'b1;
                w_byp_data = w_entries[w_idx].data;
            end
        end
    end

    assign w_head_sel  = w_head.sel;
    assign w_head_data = w_head.data;

    assign bus.in_ready     = reset & !bus.flush & (!w_full | w_pop);
    assign bus.rf_we        = w_pop;
    assign bus.rf_sel       = w_head_sel;
    assign bus.rf_data      = w_head_data;
    assign bus.write_enable = w_pop;
    assign bus.write_select = w_head_sel;
    assign bus.byp_hit      = w_byp_hit;
    assign bus.byp_data     = w_byp_data;
    assign bus.count        = w_count;
    assign bus.empty        = w_empty;
    assign bus.full         = w_full;
endmodule

// File: doc/mmx_writeback.md
# mmx_writeback

Writeback queue for the MMX register file; it sits between the MMX execute stage and the register file. It accepts completed results over a valid/ready handshake, buffers up to DEPTH of them in order, and commits one per cycle to the register file. On each commit it pulses write_select/write_enable to clear the matching pending bit in mmx_stall. It also exposes a bypass lookup so dependent reads can pick up queued results before they commit.

## Interface
Parameters:
- DEPTH, 4: queue entries; a power of two, at least 2.
- DATA_W, 64: MMX register width.
- SEL_W, 3: register select width (8 MMX registers).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; queue cleared while 0.
- in_valid  in  1  execute has a result.
- in_ready  out  1  queue can accept this cycle.
- in_reg  in  SEL_W  destination register.
- in_data  in  DATA_W  result value.
- flush  in  1  synchronous discard of all queued entries.
- stall_wb  in  1  register file write port unavailable this cycle.
- rf_we  out  1  register file write strobe.
- rf_sel  out  SEL_W  register file write address.
- rf_data  out  DATA_W  register file write data.
- write_enable  out  1  scoreboard clear strobe to mmx_stall.
- write_select  out  SEL_W  scoreboard register to clear.
- byp_sel  in  SEL_W  bypass lookup register.
- byp_hit  out  1  a queued entry targets byp_sel.
- byp_data  out  DATA_W  data of the youngest matching entry.
- count  out  $clog2(DEPTH)+1  occupancy.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

## Operation
- push = in_valid & in_ready. A push appends {in_reg, in_data} at the tail.
- pop = rf_we = !empty & !stall_wb & !flush. A pop removes the head.
- rf_sel/rf_data always show the head entry, and show 0 when empty.
- write_enable equals rf_we; write_select equals rf_sel. The scoreboard clear is in the same cycle as the register file write.
- in_ready = !flush & (!full | pop). When full, a push and a pop in the same cycle are allowed.
- Pointer and count updates:
  - Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is +1 on push only, −1 on pop only, and unchanged on push and pop together.
- flush:
  - At the next edge, count becomes 0 and head equals tail.
  - No rf_we or write_enable is issued in the flush cycle, and any push is dropped.
  - Scoreboard pending bits are not cleared by this block; mmx_stall is flushed by the same signal.
- Bypass (combinational, entries already in the queue only):
  - byp_hit is set if any valid entry has reg == byp_sel.
  - byp_data comes from the youngest matching entry, and is 0 on a miss.
  - The head counts as a match even in the cycle it pops.
- Duplicate destinations are legal. Entries commit in order, so the last write wins in the register file.

## Timing
- Reset (reset == 0):
  - count = 0, empty = 1, full = 0.
  - rf_we, write_enable, byp_hit = 0.
  - rf_sel, write_select, rf_data, byp_data = 0.
  - in_ready = 0 while reset is asserted.
- Latency: a push at edge N commits at the earliest in cycle N+1, i.e. rf_we is high before edge N+1. There is no flow-through from in_* to rf_* in the same cycle.
- Throughput is one commit per cycle when stall_wb = 0.
- stall_wb holds the head in place, and rf_* stays stable while stalled.
- Combinational paths:
  - in_ready depends on stall_wb and flush.
  - byp_* depends on byp_sel.
- Reset asserted mid-operation discards all entries immediately. No write strobe is emitted after reset asserts.

## Structure
- Shared package mmx_pkg holds:
  - MMX_NUM_REGS = 8, MMX_SEL_W = 3, MMX_DATA_W = 64.
  - A packed struct mmx_wb_entry_t {sel, data}.
- Sub-module mmx_wb_queue: entry storage, pointers, count and flush. It exports the entry array and a per-entry valid vector.
- The top level holds the handshake logic, strobe generation, and the youngest-match bypass priority encoder.

## Test plan
- Single push and commit: push {reg 3, 64'h1111}, stall_wb = 0 → next cycle rf_we = 1, rf_sel = 3, write_select = 3, write_enable = 1 → then empty = 1.
- Fill to full under stall: stall_wb = 1, push regs 0..3 → full = 1 and in_ready = 0. Then stall_wb = 0 with push {reg 5} → in_ready = 1, count stays 4, and commits come out in order 0, 1, 2, 3, 5.
- Pointer wrap: push and pop continuously for 10 cycles with DEPTH = 4 → commit order matches push order and count stays at 1.
- Bypass youngest match: queue {2, A}, {2, B}, {4, C}, byp_sel = 2 → byp_hit = 1, byp_data = B. byp_sel = 6 → byp_hit = 0, byp_data = 0.
- Flush with simultaneous push: 3 entries queued, flush = 1 and in_valid = 1 → no rf_we that cycle, in_ready = 0, count = 0 at the next edge.
- Async reset mid-stream: 2 entries queued, drop reset between clock edges → count = 0 and rf_we = 0 immediately. After release, the first push commits normally.
